decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage that replaces the purely combinational decoder in the MIPS pipeline. It sits between fetch and register-read/execute. It decodes R/I/J-type instructions, extends immediates to datapath width, and computes the writeback target. It uses a valid/ready handshake with a one-entry skid buffer, so backpressure from execute never drops an instruction.

---
 rtl/decode_stage_pkg.sv | 59 +++++
 rtl/decode_stage_decode_logic.sv | 104 ++++++++++
 rtl/decode_stage.sv | 128 ++++++++++++
 tb/tb_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants for the MIPS32 decode stage: default widths, field
// positions, opcode/funct encodings and the supported-funct lookup.
package decode_stage_pkg;

  localparam int IWIDTH_DEF   = 32;
  localparam int DWIDTH_DEF   = 32;
  localparam int AWIDTH_DEF   = 5;
  localparam int PC_WIDTH_DEF = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic funct_supported(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB,
      FN_AND, FN_OR, FN_XOR, FN_SLT: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Purely combinational MIPS32 field decode: register addresses, writeback
// target, extended immediate, jump target and illegal-instruction flag.
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int IWIDTH   = IWIDTH_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [IWIDTH-1:0]   instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [5:0]          opcode_o,
  output logic [5:0]          funct_o,
  output logic [4:0]          shamt_o,
  output logic [AWIDTH-1:0]   addr_rs_o,
  output logic [AWIDTH-1:0]   addr_rt_o,
  output logic [AWIDTH-1:0]   wr_addr_o,
  output logic                wr_en_o,
  output logic [DWIDTH-1:0]   imm_o,
  output logic [PC_WIDTH-1:0] jtarget_o,
  output logic                illegal_o
);

  logic [5:0]          op, fn;
  logic [4:0]          rs, rt, rd, sh;
  logic [15:0]         imm16;
  logic [25:0]         tgt;
  logic [DWIDTH-1:0]   imm_sext, imm_zext, imm_lui;
  logic [PC_WIDTH-1:0] pc_plus4, hi_mask;

  assign op    = instr_i[OP_HI:OP_LO];
  assign rs    = instr_i[RS_HI:RS_LO];
  assign rt    = instr_i[RT_HI:RT_LO];
  assign rd    = instr_i[RD_HI:RD_LO];
  assign sh    = instr_i[SH_HI:SH_LO];
  assign fn    = instr_i[FN_HI:FN_LO];
  assign imm16 = instr_i[IMM_HI:0];
  assign tgt   = instr_i[TGT_HI:0];

  assign imm_sext = {{(DWIDTH-16){imm16[15]}}, imm16};
  assign imm_zext = DWIDTH'(imm16);
  assign imm_lui  = DWIDTH'({imm16, 16'h0000});

  // Jump target keeps only the top four bits of pc+4, the rest comes from the word index.
  assign pc_plus4  = pc_i + PC_WIDTH'(4);
  assign hi_mask   = ~PC_WIDTH'(28'hFFF_FFFF);
  assign jtarget_o = (pc_plus4 & hi_mask) | PC_WIDTH'({tgt, 2'b00});
  assign opcode_o  = op;

  always_comb begin
    funct_o   = '0;
    shamt_o   = '0;
    addr_rs_o = '0;
    addr_rt_o = '0;
    wr_addr_o = '0;
    wr_en_o   = 1'b0;
    imm_o     = '0;
    illegal_o = 1'b0;
    case (op)
      OP_RTYPE: begin
        funct_o   = fn;
        shamt_o   = sh;
        addr_rt_o = AWIDTH'(rt);
        if (!funct_supported(fn)) begin
          illegal_o = 1'b1;
        end else begin
          if (fn != FN_SLL && fn != FN_SRL) addr_rs_o = AWIDTH'(rs);
          wr_addr_o = AWIDTH'(rd);
          wr_en_o   = (rd != 5'd0);
        end
      end
      OP_J: ;
      OP_JAL: begin
        wr_addr_o = AWIDTH'(31);
        wr_en_o   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        addr_rs_o = AWIDTH'(rs);
        addr_rt_o = AWIDTH'(rt);
        imm_o     = imm_sext;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        addr_rs_o = AWIDTH'(rs);
        imm_o     = imm_sext;
        wr_addr_o = AWIDTH'(rt);
        wr_en_o   = (rt != 5'd0);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        addr_rs_o = AWIDTH'(rs);
        imm_o     = imm_zext;
        wr_addr_o = AWIDTH'(rt);
        wr_en_o   = (rt != 5'd0);
      end
      OP_LUI: begin
        imm_o     = imm_lui;
        wr_addr_o = AWIDTH'(rt);
        wr_en_o   = (rt != 5'd0);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes once at the input, then holds the result
// in an output register backed by a one-entry skid register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int IWIDTH   = IWIDTH_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic                d_i_valid,
  output logic                d_o_ready,
  input  logic [IWIDTH-1:0]   d_i_instr,
  input  logic [PC_WIDTH-1:0] d_i_pc,
  input  logic                d_i_flush,
  output logic                d_o_valid,
  input  logic                d_i_ready,
  output logic [5:0]          d_o_opcode,
  output logic [5:0]          d_o_funct,
  output logic [4:0]          d_o_shamt,
  output logic [AWIDTH-1:0]   d_o_addr_rs,
  output logic [AWIDTH-1:0]   d_o_addr_rt,
  output logic [AWIDTH-1:0]   d_o_wr_addr,
  output logic                d_o_wr_en,
  output logic [DWIDTH-1:0]   d_o_imm,
  output logic [PC_WIDTH-1:0] d_o_jtarget,
  output logic [PC_WIDTH-1:0] d_o_pc,
  output logic                d_o_illegal,
  output logic [15:0]         d_o_illegal_cnt
);

  localparam int PW = 6 + 6 + 5 + 3*AWIDTH + 1 + DWIDTH + 2*PC_WIDTH + 1;

  logic [5:0]          dec_opcode, dec_funct;
  logic [4:0]          dec_shamt;
  logic [AWIDTH-1:0]   dec_rs, dec_rt, dec_wr_addr;
  logic                dec_wr_en, dec_illegal;
  logic [DWIDTH-1:0]   dec_imm;
  logic [PC_WIDTH-1:0] dec_jtarget;
  logic [PW-1:0]       dec_payload;

  logic [PW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          in_fire, out_fire;

  decode_logic #(
    .IWIDTH  (IWIDTH),
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .PC_WIDTH(PC_WIDTH)
  ) u_decode (
    .instr_i  (d_i_instr),
    .pc_i     (d_i_pc),
    .opcode_o (dec_opcode),
    .funct_o  (dec_funct),
    .shamt_o  (dec_shamt),
    .addr_rs_o(dec_rs),
    .addr_rt_o(dec_rt),
    .wr_addr_o(dec_wr_addr),
    .wr_en_o  (dec_wr_en),
    .imm_o    (dec_imm),
    .jtarget_o(dec_jtarget),
    .illegal_o(dec_illegal)
  );

  assign dec_payload = {dec_opcode, dec_funct, dec_shamt, dec_rs, dec_rt, dec_wr_addr,
                        dec_wr_en, dec_imm, dec_jtarget, d_i_pc, dec_illegal};

  assign {d_o_opcode, d_o_funct, d_o_shamt, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr,
          d_o_wr_en, d_o_imm, d_o_jtarget, d_o_pc, d_o_illegal} = out_q;

  assign d_o_valid       = out_valid_q;
  assign d_o_ready       = !skid_valid_q;
  assign d_o_illegal_cnt = cnt_q;

  assign in_fire  = d_i_valid && d_o_ready;
  assign out_fire = out_valid_q && d_i_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (d_i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (in_fire && dec_illegal && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      // Output register free this cycle: skid has priority over new input to keep order.
      if (out_fire || !out_valid_q) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          out_d       = dec_payload;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_d       = dec_payload;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, handshake,
// skid buffer, flush, reset and illegal-count saturation.
module tb_decode_stage;

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic        d_i_valid = 1'b0;
  logic        d_o_ready;
  logic [31:0] d_i_instr = '0;
  logic [31:0] d_i_pc = '0;
  logic        d_i_flush = 1'b0;
  logic        d_o_valid;
  logic        d_i_ready = 1'b0;
  logic [5:0]  d_o_opcode, d_o_funct;
  logic [4:0]  d_o_shamt;
  logic [4:0]  d_o_addr_rs, d_o_addr_rt, d_o_wr_addr;
  logic        d_o_wr_en;
  logic [31:0] d_o_imm, d_o_jtarget, d_o_pc;
  logic        d_o_illegal;
  logic [15:0] d_o_illegal_cnt;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_valid(d_i_valid), .d_o_ready(d_o_ready),
    .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_flush(d_i_flush),
    .d_o_valid(d_o_valid), .d_i_ready(d_i_ready), .d_o_opcode(d_o_opcode),
    .d_o_funct(d_o_funct), .d_o_shamt(d_o_shamt), .d_o_addr_rs(d_o_addr_rs),
    .d_o_addr_rt(d_o_addr_rt), .d_o_wr_addr(d_o_wr_addr), .d_o_wr_en(d_o_wr_en),
    .d_o_imm(d_o_imm), .d_o_jtarget(d_o_jtarget), .d_o_pc(d_o_pc),
    .d_o_illegal(d_o_illegal), .d_o_illegal_cnt(d_o_illegal_cnt)
  );

  always #5 d_clk = ~d_clk;

  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    d_i_valid = v;
    d_i_instr = instr;
    d_i_pc    = pc;
  endtask

  task automatic do_reset();
    d_rst = 1'b0;
    tick();
    tick();
    d_rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h2128FFFC, 32'h40);
    d_i_ready = 1'b1;
    do_reset();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_handshake: valid,ready=%b required 01", {d_o_valid, d_o_ready});
    end
    checks++;
    if (d_o_illegal_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h required 0000", d_o_illegal_cnt);
    end
    checks++;
    if ({d_o_opcode, d_o_funct, d_o_shamt, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr,
         d_o_wr_en, d_o_imm, d_o_jtarget, d_o_pc, d_o_illegal} !== 130'h0) begin
      errors++; $display("FAIL reset_payload: payload not zero, imm=%h pc=%h", d_o_imm, d_o_pc);
    end
  endtask

  task automatic test_addi();
    d_i_ready = 1'b1;
    drive(1'b1, 32'h2128FFFC, 32'h1000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_opcode, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr, d_o_wr_en, d_o_illegal}
        !== {1'b1, 6'h08, 5'd9, 5'd0, 5'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL addi_fields: v=%b op=%h rs=%0d rt=%0d wa=%0d we=%b il=%b required 1 08 9 0 8 1 0",
                         d_o_valid, d_o_opcode, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr, d_o_wr_en, d_o_illegal);
    end
    checks++;
    if ({d_o_imm, d_o_pc} !== {32'hFFFFFFFC, 32'h1000}) begin
      errors++; $display("FAIL addi_imm: imm=%h pc=%h required fffffffc 00001000", d_o_imm, d_o_pc);
    end
    tick();
    checks++;
    if (d_o_valid !== 1'b0) begin
      errors++; $display("FAIL addi_drain: valid=%b required 0", d_o_valid);
    end
  endtask

  task automatic test_back_to_back();
    d_i_ready = 1'b1;
    drive(1'b1, 32'h34038001, 32'h2000);
    tick();
    drive(1'b1, 32'h3C051234, 32'h2004);
    checks++;
    if ({d_o_valid, d_o_imm, d_o_addr_rs, d_o_wr_addr, d_o_wr_en} !== {1'b1, 32'h00008001, 5'd0, 5'd3, 1'b1}) begin
      errors++; $display("FAIL ori: v=%b imm=%h rs=%0d wa=%0d we=%b required 1 00008001 0 3 1",
                         d_o_valid, d_o_imm, d_o_addr_rs, d_o_wr_addr, d_o_wr_en);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_imm, d_o_addr_rs, d_o_wr_addr, d_o_wr_en, d_o_pc}
        !== {1'b1, 32'h12340000, 5'd0, 5'd5, 1'b1, 32'h2004}) begin
      errors++; $display("FAIL lui: v=%b imm=%h rs=%0d wa=%0d we=%b pc=%h required 1 12340000 0 5 1 00002004",
                         d_o_valid, d_o_imm, d_o_addr_rs, d_o_wr_addr, d_o_wr_en, d_o_pc);
    end
    tick();
  endtask

  task automatic test_jumps();
    d_i_ready = 1'b1;
    drive(1'b1, 32'h0C000040, 32'h00400000);
    tick();
    drive(1'b1, 32'h08000040, 32'h1FFFFFFC);
    checks++;
    if ({d_o_wr_addr, d_o_wr_en, d_o_jtarget, d_o_addr_rs, d_o_imm} !== {5'd31, 1'b1, 32'h00000100, 5'd0, 32'h0}) begin
      errors++; $display("FAIL jal: wa=%0d we=%b jt=%h rs=%0d imm=%h required 31 1 00000100 0 0",
                         d_o_wr_addr, d_o_wr_en, d_o_jtarget, d_o_addr_rs, d_o_imm);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_wr_addr, d_o_wr_en, d_o_jtarget} !== {5'd0, 1'b0, 32'h20000100}) begin
      errors++; $display("FAIL j_hi: wa=%0d we=%b jt=%h required 0 0 20000100", d_o_wr_addr, d_o_wr_en, d_o_jtarget);
    end
    tick();
  endtask

  task automatic test_backpressure();
    d_i_ready = 1'b0;
    drive(1'b1, 32'h00225020, 32'h200);   // ADD $10,$1,$2
    tick();
    checks++;
    if ({d_o_valid, d_o_ready, d_o_pc} !== {1'b1, 1'b1, 32'h200}) begin
      errors++; $display("FAIL bp_first: v=%b rdy=%b pc=%h required 1 1 00000200", d_o_valid, d_o_ready, d_o_pc);
    end
    drive(1'b1, 32'hAFA40008, 32'h204);   // SW $4,8($29)
    tick();
    checks++;
    if ({d_o_valid, d_o_ready, d_o_pc} !== {1'b1, 1'b0, 32'h200}) begin
      errors++; $display("FAIL bp_skid: v=%b rdy=%b pc=%h required 1 0 00000200", d_o_valid, d_o_ready, d_o_pc);
    end
    drive(1'b1, 32'h00041880, 32'h208);   // SLL $3,$4,2
    tick();
    checks++;
    if ({d_o_valid, d_o_ready, d_o_pc, d_o_wr_addr, d_o_funct} !== {1'b1, 1'b0, 32'h200, 5'd10, 6'h20}) begin
      errors++; $display("FAIL bp_hold: v=%b rdy=%b pc=%h wa=%0d fn=%h required 1 0 00000200 10 20",
                         d_o_valid, d_o_ready, d_o_pc, d_o_wr_addr, d_o_funct);
    end
    d_i_ready = 1'b1;
    tick();
    checks++;
    if ({d_o_valid, d_o_ready, d_o_pc, d_o_addr_rs, d_o_addr_rt, d_o_wr_en, d_o_imm}
        !== {1'b1, 1'b1, 32'h204, 5'd29, 5'd4, 1'b0, 32'h8}) begin
      errors++; $display("FAIL bp_second: v=%b rdy=%b pc=%h rs=%0d rt=%0d we=%b imm=%h required 1 1 00000204 29 4 0 8",
                         d_o_valid, d_o_ready, d_o_pc, d_o_addr_rs, d_o_addr_rt, d_o_wr_en, d_o_imm);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_pc, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr, d_o_shamt}
        !== {1'b1, 32'h208, 5'd0, 5'd4, 5'd3, 5'd2}) begin
      errors++; $display("FAIL bp_third: v=%b pc=%h rs=%0d rt=%0d wa=%0d sh=%0d required 1 00000208 0 4 3 2",
                         d_o_valid, d_o_pc, d_o_addr_rs, d_o_addr_rt, d_o_wr_addr, d_o_shamt);
    end
    tick();
    checks++;
    if (d_o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: valid=%b required 0", d_o_valid);
    end
  endtask

  task automatic test_flush();
    d_i_ready = 1'b0;
    drive(1'b1, 32'h00225020, 32'h300);
    tick();
    drive(1'b1, 32'h34038001, 32'h304);
    tick();
    checks++;
    if ({d_o_valid, d_o_ready} !== 2'b10) begin
      errors++; $display("FAIL flush_full: valid,ready=%b required 10", {d_o_valid, d_o_ready});
    end
    d_i_flush = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h308);
    tick();
    d_i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_clear: valid,ready=%b required 01", {d_o_valid, d_o_ready});
    end
    // Accepted-but-flushed illegal must not reach the counter.
    d_i_ready = 1'b1;
    d_i_flush = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h30C);
    tick();
    d_i_flush = 1'b0;
    drive(1'b1, 32'h3C051234, 32'h310);
    checks++;
    if ({d_o_valid, d_o_illegal_cnt} !== {1'b0, 16'h0}) begin
      errors++; $display("FAIL flush_discard: v=%b cnt=%h required 0 0000", d_o_valid, d_o_illegal_cnt);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_pc, d_o_imm, d_o_wr_addr} !== {1'b1, 32'h310, 32'h12340000, 5'd5}) begin
      errors++; $display("FAIL flush_after: v=%b pc=%h imm=%h wa=%0d required 1 00000310 12340000 5",
                         d_o_valid, d_o_pc, d_o_imm, d_o_wr_addr);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    d_i_ready = 1'b0;
    drive(1'b1, 32'h00225020, 32'h400);
    tick();
    drive(1'b1, 32'h00225020, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    d_rst = 1'b0;
    tick();
    d_rst = 1'b1;
    checks++;
    if ({d_o_valid, d_o_ready, d_o_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_mid: v=%b rdy=%b pc=%h required 0 1 00000000", d_o_valid, d_o_ready, d_o_pc);
    end
    d_i_ready = 1'b1;
    tick();
    checks++;
    if (d_o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_skid: valid=%b required 0 (skid not discarded)", d_o_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    d_i_ready = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h500);
    tick();
    drive(1'b1, 32'h0000003F, 32'h504);
    checks++;
    if ({d_o_valid, d_o_illegal, d_o_wr_en, d_o_opcode, d_o_illegal_cnt} !== {1'b1, 1'b1, 1'b0, 6'h3F, 16'd1}) begin
      errors++; $display("FAIL ill_opcode: v=%b il=%b we=%b op=%h cnt=%h required 1 1 0 3f 0001",
                         d_o_valid, d_o_illegal, d_o_wr_en, d_o_opcode, d_o_illegal_cnt);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({d_o_valid, d_o_illegal, d_o_wr_en, d_o_funct, d_o_illegal_cnt} !== {1'b1, 1'b1, 1'b0, 6'h3F, 16'd2}) begin
      errors++; $display("FAIL ill_funct: v=%b il=%b we=%b fn=%h cnt=%h required 1 1 0 3f 0002",
                         d_o_valid, d_o_illegal, d_o_wr_en, d_o_funct, d_o_illegal_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    d_i_ready = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h600);
    repeat (65534) tick();
    checks++;
    if (d_o_illegal_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre: cnt=%h required fffe", d_o_illegal_cnt);
    end
    tick();
    checks++;
    if (d_o_illegal_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: cnt=%h required ffff", d_o_illegal_cnt);
    end
    repeat (3) tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (d_o_illegal_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: cnt=%h required ffff", d_o_illegal_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jumps();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_illegal();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
